dmem_responder: RTL and testbench

- Responder end of the core's data-memory port: accepts `MemWrite`, `byteEnable`, `ALUResult` (address) and `WriteData` from `arm`, and returns `ReadData`.
- Backs the port with a word-organised RAM that supports byte-lane writes, plus a small memory-mapped I/O window.
- The window holds a free-running cycle counter and an 8-deep byte output FIFO, drained over a valid/ready handshake.
- Sits beside the instruction memory at the top level; the core needs no change.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_responder_tx_fifo.sv | 69 ++++++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// STATUS/CTRL bit positions and the offset decoder.
package dmem_pkg;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [2:0] {
    REG_CYCLE,
    REG_TXDATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } mmio_reg_e;

  // Offsets are matched on all eight window bits; anything else is a hole.
  function automatic mmio_reg_e decode_reg(input logic [7:0] off);
    case (off)
      OFF_CYCLE:  return REG_CYCLE;
      OFF_TXDATA: return REG_TXDATA;
      OFF_STATUS: return REG_STATUS;
      OFF_CTRL:   return REG_CTRL;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte FIFO feeding the TX handshake. Flush and reset rewind both pointers;
// a push into a full FIFO survives only if a pop frees a slot that cycle.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !flush;
  assign drop    = push && full && !do_pop;
  assign count   = count_reg;

  // Storage is never cleared, so the head is masked to zero when empty.
  assign head = empty ? 8'h00 : mem_reg[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM plus an MMIO window with a cycle
// counter and a TX byte FIFO. Reads are combinational, writes land on the edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic              is_mmio;
  mmio_reg_e         reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic [31:0]       ram_rdata;

  logic [31:0]       cycle_reg, cycle_next;
  logic              ovf_reg, ovf_next;

  logic              fifo_push, fifo_flush, clr_ovf, ctrl_wr;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic [31:0]       status_word;

  assign is_mmio = (ALUResult[31:8] == MMIO_BASE[31:8]);
  assign reg_sel = decode_reg(ALUResult[7:0]);
  assign ram_idx = ALUResult[RAM_AW+1:2];
  // Stores are suppressed for the whole reset cycle, RAM included.
  assign wr_en   = MemWrite && !reset;

  // One RAM per byte lane so each lane has a single write port.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg [MEM_WORDS];

      always_ff @(posedge clk) begin
        if (wr_en && !is_mmio && byteEnable[gi])
          lane_reg[ram_idx] <= WriteData[8*gi +: 8];
      end

      assign ram_rdata[8*gi +: 8] = lane_reg[ram_idx];
    end
  endgenerate

  assign fifo_push  = wr_en && is_mmio && (reg_sel == REG_TXDATA) && byteEnable[0];
  assign ctrl_wr    = wr_en && is_mmio && (reg_sel == REG_CTRL) && byteEnable[0];
  assign fifo_flush = ctrl_wr && WriteData[CTRL_FLUSH];
  assign clr_ovf    = ctrl_wr && WriteData[CTRL_CLR_OVF];

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (tx_ready),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign tx_data  = fifo_head;
  assign tx_valid = !fifo_empty;

  always_comb begin
    cycle_next = cycle_reg + 32'd1;
    ovf_next   = ovf_reg;
    if (fifo_drop)    ovf_next = 1'b1;
    else if (clr_ovf) ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      cycle_reg <= cycle_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    status_word           = '0;
    status_word[7:0]      = 8'(fifo_count);
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = ovf_reg;
  end

  always_comb begin
    ReadData = '0;
    if (is_mmio) begin
      case (reg_sel)
        REG_CYCLE:  ReadData = cycle_reg;
        REG_STATUS: ReadData = status_word;
        default:    ReadData = '0;
      endcase
    end else begin
      ReadData = ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: a word/queue reference model feeds
// read and TX scoreboards that a negedge monitor drains and compares.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [3:0]  byteEnable;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .byteEnable (byteEnable),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF0C;

  int checks = 0;
  int fails  = 0;

  // Reference model state, always describing the DUT just after the last edge.
  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  string       rdn_q[$];
  logic [31:0] mem_m [64];
  logic [3:0]  lane_ok [64];
  logic        ovf_m = 1'b0;
  logic [31:0] cyc_m = '0;
  bit          rd_chk = 0;
  bit          mon_en = 0;

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int n;
    n = tx_q.size();
    if (addr[31:8] == 24'hFFFFFF) begin
      case (addr[7:0])
        8'h00: return cyc_m;
        8'h08: return {21'd0, ovf_m, (n == 8), (n == 0), 8'(n)};
        default: return 32'h0;
      endcase
    end
    return mem_m[addr[7:2]];
  endfunction

  // Monitor: checks the TX stream and any read the driver flagged this cycle.
  always @(negedge clk) begin
    logic [7:0]  exp_b;
    logic [31:0] exp_w;
    string       nm;
    if (mon_en) begin
      checks++;
      if (tx_valid !== (tx_q.size() != 0)) begin
        fails++;
        $display("FAIL tx_valid: got %b, expected %b", tx_valid, tx_q.size() != 0);
      end
      if (tx_q.size() == 0) begin
        checks++;
        if (tx_data !== 8'h00) begin
          fails++;
          $display("FAIL tx_data_idle: got %h, expected 00", tx_data);
        end
      end else if (tx_valid === 1'b1 && tx_ready) begin
        exp_b = tx_q.pop_front();
        checks++;
        if (tx_data !== exp_b) begin
          fails++;
          $display("FAIL tx_pop: got %h, expected %h", tx_data, exp_b);
        end else
          $display("[%0t] tx pop %h", $time, tx_data);
      end
      if (rd_chk) begin
        exp_w = rd_q.pop_front();
        nm    = rdn_q.pop_front();
        checks++;
        if (ReadData !== exp_w) begin
          fails++;
          $display("FAIL read %s addr=%h: got %h, expected %h", nm, ALUResult, ReadData, exp_w);
        end else
          $display("[%0t] read %s addr=%h data=%h", $time, nm, ALUResult, ReadData);
      end
    end
  end

  // One clock: drive inputs, expect the pre-edge read, then advance the model.
  task automatic step(input bit rst, input bit we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input bit rdy, input bit chk, input string name);
    bit mmio;
    reset = rst; MemWrite = we; byteEnable = be;
    ALUResult = addr; WriteData = wd; tx_ready = rdy;
    if (chk) begin
      rd_q.push_back(model_read(addr));
      rdn_q.push_back(name);
    end
    rd_chk = chk;
    mmio = (addr[31:8] == 24'hFFFFFF);
    @(posedge clk);
    #1;
    rd_chk = 0;
    MemWrite = 1'b0;
    cyc_m = rst ? 32'h0 : cyc_m + 32'd1;
    if (rst) begin
      tx_q.delete();
      ovf_m = 1'b0;
    end else if (we && !mmio) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) begin
          mem_m[addr[7:2]][8*i +: 8] = wd[8*i +: 8];
          lane_ok[addr[7:2]][i] = 1'b1;
        end
    end else if (we && be[0] && addr[7:0] == 8'h0C) begin
      if (wd[1]) tx_q.delete();
      if (wd[0]) ovf_m = 1'b0;
    end else if (we && be[0] && addr[7:0] == 8'h04) begin
      // Any pop this cycle already left the queue in the monitor.
      if (tx_q.size() < 8) tx_q.push_back(wd[7:0]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit rdy);
    step(0, 1, be, a, d, rdy, 0, "");
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input bit rdy);
    step(0, 0, 4'h0, a, 32'h0, rdy, 1, nm);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "");
  endtask

  initial begin
    logic [31:0] a, d;
    logic [5:0]  idx;
    int          r;
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = '0;
      lane_ok[i] = '0;
    end
    reset = 1'b1; MemWrite = 1'b0; byteEnable = '0;
    ALUResult = '0; WriteData = '0; tx_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Reset values, and stores ignored while reset is high.
    step(1, 0, 4'h0, A_STATUS, 0, 0, 1, "rst_status");
    step(1, 0, 4'h0, A_CYCLE, 0, 0, 1, "rst_cycle");
    step(1, 1, 4'h1, A_TXDATA, 32'h77, 0, 0, "");
    rd(A_STATUS, "rst_status2", 0);

    // Byte lanes.
    wr(32'h10, 32'hAABBCCDD, 4'hF, 0);
    wr(32'h11, 32'h11223344, 4'h5, 0);
    rd(32'h10, "lanes", 0);

    // Read-after-write returns old data, then new data.
    wr(32'h20, 32'hDEAD0000, 4'hF, 0);
    step(0, 1, 4'hF, 32'h20, 32'h5, 0, 1, "raw_old");
    rd(32'h20, "raw_new", 0);

    // Cycle counter advance and wrap.
    rd(A_CYCLE, "cycle_a", 0);
    drain(5);
    rd(A_CYCLE, "cycle_b", 0);
    force dut.cycle_reg = 32'hFFFF_FFFF;
    release dut.cycle_reg;
    cyc_m = 32'hFFFF_FFFF;
    rd(A_CYCLE, "cycle_max", 0);
    rd(A_CYCLE, "cycle_wrap", 0);

    // Overflow with the consumer stalled, then drain and clear.
    for (int i = 1; i <= 9; i++) wr(A_TXDATA, 32'(i), 4'h1, 0);
    rd(A_STATUS, "ovf_status", 0);
    drain(10);
    rd(A_STATUS, "ovf_drained", 0);
    wr(A_CTRL, 32'h1, 4'h1, 0);
    rd(A_STATUS, "ovf_cleared", 0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'h60 + 32'(i), 4'h1, 0);
    wr(A_TXDATA, 32'h42, 4'h1, 1);
    rd(A_STATUS, "full_pushpop", 0);
    drain(10);

    // Reset and flush mid-stream.
    wr(32'h30, 32'hCAFEBABE, 4'hF, 0);
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'hA0 + 32'(i), 4'h1, 0);
    step(1, 0, 4'h0, 32'h0, 0, 0, 0, "");
    rd(A_STATUS, "reset_status", 0);
    rd(32'h30, "reset_ram", 0);
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'hB0 + 32'(i), 4'h1, 0);
    wr(A_CTRL, 32'h2, 4'h1, 1);
    rd(A_STATUS, "flush_status", 0);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      a = $urandom;
      d = $urandom;
      if (a[31:8] == 24'hFFFFFF) a[31] = 1'b0;
      if (r < 1) begin
        step(1, 0, 4'h0, a, d, $urandom_range(0, 1), 0, "");
      end else if (r < 20) begin
        wr(a, d, 4'($urandom), $urandom_range(0, 1));
      end else if (r < 35) begin
        idx = 6'($urandom);
        a[7:2] = idx;
        if (lane_ok[idx] == 4'hF) rd(a, "rand_ram", $urandom_range(0, 1));
        else rd(A_CYCLE, "rand_cycle", $urandom_range(0, 1));
      end else if (r < 60) begin
        wr(A_TXDATA, d, 4'($urandom), $urandom_range(0, 3) == 0);
      end else if (r < 70) begin
        rd(A_STATUS, "rand_status", $urandom_range(0, 1));
      end else if (r < 75) begin
        rd(A_CYCLE, "rand_cycle", $urandom_range(0, 1));
      end else if (r < 80) begin
        wr(A_CTRL, {30'd0, d[1:0]}, 4'($urandom), $urandom_range(0, 1));
      end else if (r < 88) begin
        a = {24'hFFFFFF, 8'($urandom_range(4, 63) * 4)};
        if (a[7:0] == 8'h08) a = A_TXDATA;
        rd(a, "rand_hole", $urandom_range(0, 1));
      end else if (r < 93) begin
        wr($urandom_range(0, 1) ? A_CYCLE : A_STATUS, d, 4'hF, $urandom_range(0, 1));
      end else begin
        drain(1);
      end
    end
    drain(12);
    rd(A_STATUS, "final_status", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
